hazard_ctrl: RTL

Pipeline hazard controller for the 5-stage MIPS-style core. It sequences the stage enables and flushes of the pipeline registers, including the decode/control stage `ena`. It resolves load-use hazards (a programmable number of bubble cycles), taken branches resolved in MEM, jumps decoded in ID, and data-memory wait states. It sits beside the decode stage and drives every pipeline-register enable/flush in the core.

---
 rtl/hazard_ctrl.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, MEM-resolved branch flush, ID jump squash, data-memory wait freeze.
// Optional `HAZARD_PERF_EN adds saturating stall/flush/wait counters.
module hazard_ctrl #(
    parameter int LU_STALL_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rt,
    input  logic       id_jump,
    input  logic       ex_memtoreg,
    input  logic       ex_regwrite,
    input  logic [4:0] ex_rd,
    input  logic       mem_branch_taken,
    input  logic       mem_req,
    input  logic       mem_ready,
    output logic       pc_ena,
    output logic       ifid_ena,
    output logic       ifid_flush,
    output logic       idex_flush,
    output logic       exmem_flush,
    output logic       back_ena,
    output logic [1:0] state
`ifdef HAZARD_PERF_EN
    ,
    output logic [15:0] perf_stall,
    output logic [15:0] perf_flush,
    output logic [15:0] perf_wait
`endif
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2
    } st_t;

    // Out-of-range settings are clamped so the 2-bit counter can always hold the reload value.
    localparam int         LU_CLAMP = (LU_STALL_CYCLES < 1) ? 1 :
                                      (LU_STALL_CYCLES > 3) ? 3 : LU_STALL_CYCLES;
    localparam logic [1:0] LU_LOAD  = 2'(LU_CLAMP - 1);

    st_t        cur_st, nxt_st;
    st_t        ret_st, nxt_ret;
    st_t        eff_st;
    logic [1:0] lu_cnt, nxt_cnt;
    logic       lu_hit;
    logic       mem_wait;
    logic       stall_cont;
    logic       stall_cond;

    always_comb begin
        lu_hit = ex_memtoreg & ex_regwrite & (ex_rd != 5'd0) &
                 ((ex_rd == id_rs) | (id_uses_rt & (ex_rd == id_rt)));
        mem_wait = mem_req & ~mem_ready;
        // While frozen, decisions are taken against the state that was interrupted.
        eff_st     = (cur_st == MEM_WAIT) ? ret_st : cur_st;
        stall_cont = (eff_st == LU_STALL) && (lu_cnt != 2'd0);
        stall_cond = lu_hit | stall_cont;
    end

    always_comb begin
        pc_ena      = 1'b1;
        ifid_ena    = 1'b1;
        back_ena    = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        nxt_st      = RUN;
        nxt_cnt     = 2'd0;
        nxt_ret     = ret_st;
        if (rst) begin
            pc_ena      = 1'b0;
            ifid_ena    = 1'b0;
            back_ena    = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
        end else if (mem_wait) begin
            pc_ena   = 1'b0;
            ifid_ena = 1'b0;
            back_ena = 1'b0;
            nxt_st   = MEM_WAIT;
            nxt_ret  = eff_st;
            nxt_cnt  = lu_cnt;
        end else if (mem_branch_taken) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
        end else if (stall_cond) begin
            pc_ena     = 1'b0;
            ifid_ena   = 1'b0;
            idex_flush = 1'b1;
            if (stall_cont) begin
                nxt_cnt = lu_cnt - 2'd1;
                nxt_st  = (lu_cnt == 2'd1) ? RUN : LU_STALL;
            end else begin
                nxt_cnt = LU_LOAD;
                nxt_st  = (LU_LOAD != 2'd0) ? LU_STALL : RUN;
            end
        end else if (id_jump) begin
            ifid_flush = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_st <= RUN;
            ret_st <= RUN;
            lu_cnt <= 2'd0;
        end else begin
            cur_st <= nxt_st;
            ret_st <= nxt_ret;
            lu_cnt <= nxt_cnt;
        end
    end

    assign state = cur_st;

`ifdef HAZARD_PERF_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic ev_stall, ev_flush, ev_wait;

    always_comb begin
        ev_wait  = mem_wait;
        ev_flush = ~mem_wait & mem_branch_taken;
        ev_stall = ~mem_wait & ~mem_branch_taken & stall_cond;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall <= 16'd0;
            perf_flush <= 16'd0;
            perf_wait  <= 16'd0;
        end else begin
            if (ev_stall) perf_stall <= sat_inc(perf_stall);
            if (ev_flush) perf_flush <= sat_inc(perf_flush);
            if (ev_wait)  perf_wait  <= sat_inc(perf_wait);
        end
    end
`endif

endmodule
